// File: rtl/abs_stream_if.sv
// rtl/abs_stream_if.sv - input/output stream bundle for abs_stream
interface abs_stream_if #(
    parameter int NUM_WIDTH = 16,
    parameter int NUM_CH    = 1
);
    logic                          in_valid;
    logic                          in_ready;
    logic [NUM_CH*NUM_WIDTH-1:0]   ans;
    logic                          out_valid;
    logic                          out_ready;
    logic [NUM_CH*NUM_WIDTH-1:0]   abs_ans;
    logic [NUM_CH-1:0]             sign;
    logic [NUM_CH-1:0]             ovf;

    modport master (
        output in_valid, ans, out_ready,
        input  in_ready, out_valid, abs_ans, sign, ovf
    );

    modport slave (
        input  in_valid, ans, out_ready,
        output in_ready, out_valid, abs_ans, sign, ovf
    );
endinterface

// File: rtl/abs_stream.sv
// rtl/abs_stream.sv - two-stage per-lane absolute value with handshake; ABS_SAT_EN clamps 100..0 to 011..1
module abs_stream #(
    parameter int NUM_WIDTH = 16,
    parameter int NUM_CH    = 1,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    abs_stream_if.slave          s,
    output logic [CNT_WIDTH-1:0] ovf_count
);
    localparam int DW = NUM_CH * NUM_WIDTH;
    localparam logic [NUM_WIDTH-1:0] MOST_NEG = {1'b1, {(NUM_WIDTH-1){1'b0}}};
    localparam logic [NUM_WIDTH-1:0] MAX_POS  = {1'b0, {(NUM_WIDTH-1){1'b1}}};

    logic              s1_valid;
    logic [DW-1:0]     s1_data;
    logic [NUM_CH-1:0] s1_msb;
    logic              s1_en;
    logic              s2_en;

    logic [NUM_CH-1:0]    in_msb;
    logic [DW-1:0]        mag;
    logic [NUM_CH-1:0]    lane_ovf;
    logic [NUM_WIDTH-1:0] lane;

    assign s2_en      = !s.out_valid || s.out_ready;
    assign s1_en      = !s1_valid || s2_en;
    assign s.in_ready = s1_en && !rst;

    always_comb begin
        in_msb = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            in_msb[k] = s.ans[k*NUM_WIDTH + NUM_WIDTH - 1];
        end
    end

    // The most-negative lane has no positive counterpart; it wraps unless clamping is built in.
    always_comb begin
        mag      = '0;
        lane_ovf = '0;
        lane     = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            lane        = s1_data[k*NUM_WIDTH +: NUM_WIDTH];
            lane_ovf[k] = (lane == MOST_NEG);
            mag[k*NUM_WIDTH +: NUM_WIDTH] = s1_msb[k] ? (~lane + NUM_WIDTH'(1)) : lane;
`ifdef ABS_SAT_EN
            if (lane_ovf[k]) begin
                mag[k*NUM_WIDTH +: NUM_WIDTH] = MAX_POS;
            end
`else
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_msb   <= '0;
        end else if (s1_en) begin
            s1_valid <= s.in_valid;
            if (s.in_valid) begin
                s1_data <= s.ans;
                s1_msb  <= in_msb;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s.out_valid <= 1'b0;
            s.abs_ans   <= '0;
            s.sign      <= '0;
            s.ovf       <= '0;
        end else if (s2_en) begin
            s.out_valid <= s1_valid;
            if (s1_valid) begin
                s.abs_ans <= mag;
                s.sign    <= s1_msb;
                s.ovf     <= lane_ovf;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_count <= '0;
        end else if (s.out_valid && s.out_ready && (|s.ovf) && (ovf_count != '1)) begin
            ovf_count <= ovf_count + CNT_WIDTH'(1);
        end
    end
endmodule

// File: tb/tb_abs_stream.sv
// tb/tb_abs_stream.sv - randomized scoreboard bench for abs_stream (4 lanes, 3-bit counter)
module tb_abs_stream;
    localparam int NW = 16;
    localparam int NC = 4;
    localparam int CW = 3;
    localparam int DW = NW * NC;

    logic          clk = 1'b0;
    logic          rst;
    logic [CW-1:0] ovf_count;

    abs_stream_if #(.NUM_WIDTH(NW), .NUM_CH(NC)) bus();

    abs_stream #(.NUM_WIDTH(NW), .NUM_CH(NC), .CNT_WIDTH(CW)) dut (
        .clk(clk),
        .rst(rst),
        .s(bus),
        .ovf_count(ovf_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        int            acc;
    } beat_t;

    beat_t         q[$];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            exp_cnt = 0;
    int            n_pushed = 0;
    int            n_rdy_low = 0;
    bit            started = 0;
    bit            lat_chk = 0;
    bit            have_hold = 0;
    logic [DW-1:0] held_abs;
    logic [NC-1:0] held_sign;
    logic [NC-1:0] held_ovf;

    function automatic void model(input logic [DW-1:0] d, output logic [DW-1:0] a,
                                  output logic [NC-1:0] sg, output logic [NC-1:0] of);
        a = '0; sg = '0; of = '0;
        for (int k = 0; k < NC; k++) begin
            int v;
            int m;
            v = int'($signed(d[k*NW +: NW]));
            m = (v < 0) ? -v : v;
`ifdef ABS_SAT_EN
            if (v == -(1 << (NW-1))) m = (1 << (NW-1)) - 1;
`endif
            a[k*NW +: NW] = m[NW-1:0];
            sg[k] = (v < 0);
            of[k] = (v == -(1 << (NW-1)));
        end
    endfunction

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int k = 0; k < NC; k++) begin
            case ($urandom_range(0, 7))
                0: d[k*NW +: NW] = 16'h8000;
                1: d[k*NW +: NW] = 16'h0000;
                2: d[k*NW +: NW] = 16'h7FFF;
                3: d[k*NW +: NW] = 16'hFFFF;
                default: d[k*NW +: NW] = NW'($urandom);
            endcase
        end
        return d;
    endfunction

    task automatic step(input logic v, input logic [DW-1:0] d, input logic ordy, input logic r);
        logic [DW-1:0] ea;
        logic [NC-1:0] es;
        logic [NC-1:0] eo;
        logic          exp_rdy;
        beat_t         b;
        rst = r; bus.in_valid = v; bus.ans = d; bus.out_ready = ordy;
        #3;
        if (started) begin
            checks++;
            if (ovf_count !== CW'(exp_cnt)) begin
                errors++; $display("FAIL ovf_count got %0d want %0d", ovf_count, exp_cnt);
            end
            exp_rdy = !r && !(q.size() == 2 && !ordy);
            checks++;
            if (bus.in_ready !== exp_rdy) begin
                errors++; $display("FAIL in_ready got %b want %b (inflight %0d)", bus.in_ready, exp_rdy, q.size());
            end
            if (!r && bus.in_ready === 1'b0) n_rdy_low++;
            if (have_hold) begin
                checks++;
                if (bus.out_valid !== 1'b1 || bus.abs_ans !== held_abs || bus.sign !== held_sign || bus.ovf !== held_ovf) begin
                    errors++; $display("FAIL stall_stable got v%b %h %b %b want v1 %h %b %b", bus.out_valid, bus.abs_ans, bus.sign, bus.ovf, held_abs, held_sign, held_ovf);
                end
            end
        end
        if (r) begin
            q.delete(); exp_cnt = 0; have_hold = 0;
        end else if (started) begin
            have_hold = 0;
            if (bus.out_valid === 1'b1) begin
                if (q.size() == 0) begin
                    checks++; errors++; $display("FAIL spurious_beat got %h want none", bus.abs_ans);
                end else if (ordy) begin
                    b = q.pop_front();
                    model(b.d, ea, es, eo);
                    checks++;
                    if (bus.abs_ans !== ea) begin errors++; $display("FAIL abs_ans got %h want %h (in %h)", bus.abs_ans, ea, b.d); end
                    checks++;
                    if (bus.sign !== es) begin errors++; $display("FAIL sign got %b want %b", bus.sign, es); end
                    checks++;
                    if (bus.ovf !== eo) begin errors++; $display("FAIL ovf got %b want %b", bus.ovf, eo); end
                    if (lat_chk) begin
                        checks++;
                        if (cyc - b.acc !== 2) begin errors++; $display("FAIL latency got %0d want 2", cyc - b.acc); end
                    end
                    if (|eo && exp_cnt < (1 << CW) - 1) exp_cnt++;
                end else begin
                    have_hold = 1; held_abs = bus.abs_ans; held_sign = bus.sign; held_ovf = bus.ovf;
                end
            end
            if (v && bus.in_ready === 1'b1) begin
                q.push_back('{d: d, acc: cyc});
                n_pushed++;
            end
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q.size() > 0; i++) step(1'b0, '0, 1'b1, 1'b0);
        checks++;
        if (q.size() != 0) begin errors++; $display("FAIL drain got %0d pending want 0", q.size()); end
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_reset();
        step(1'b0, '0, 1'b0, 1'b1);
        started = 1;
        step(1'b0, '0, 1'b0, 1'b1);
        checks++;
        if ({bus.out_valid, bus.abs_ans, bus.sign, bus.ovf} !== '0) begin
            errors++; $display("FAIL reset_outputs got v%b %h %b %b want all zero", bus.out_valid, bus.abs_ans, bus.sign, bus.ovf);
        end
        step(1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_directed();
        logic [NW-1:0] din[3];
        logic [NW-1:0] dexp[3];
        logic          sexp[3];
        din  = '{16'h0F50, 16'hFF50, 16'hFFFF};
        dexp = '{16'h0F50, 16'h00B0, 16'h0001};
        sexp = '{1'b0, 1'b1, 1'b1};
        lat_chk = 1;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, DW'(din[i]), 1'b1, 1'b0);
            step(1'b0, '0, 1'b1, 1'b0);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.abs_ans !== DW'(dexp[i]) || bus.sign !== NC'(sexp[i])) begin
                errors++; $display("FAIL directed_%0d got v%b %h %b want v1 %h %b", i, bus.out_valid, bus.abs_ans, bus.sign, DW'(dexp[i]), NC'(sexp[i]));
            end
        end
        drain();
        lat_chk = 0;
    endtask

    task automatic test_overflow();
        logic [NW-1:0] want;
`ifdef ABS_SAT_EN
        want = 16'h7FFF;
`else
        want = 16'h8000;
`endif
        step(1'b1, DW'(16'h8000), 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.abs_ans !== DW'(want) || bus.sign !== 4'b0001 || bus.ovf !== 4'b0001) begin
            errors++; $display("FAIL overflow got v%b %h %b %b want v1 %h 0001 0001", bus.out_valid, bus.abs_ans, bus.sign, bus.ovf, DW'(want));
        end
        drain();
        checks++;
        if (ovf_count !== 3'd1) begin errors++; $display("FAIL overflow_count got %0d want 1", ovf_count); end
    endtask

    task automatic test_multilane();
        logic [DW-1:0] want;
`ifdef ABS_SAT_EN
        want = {16'h0002, 16'h7FFF, 16'h0000, 16'h7FFF};
`else
        want = {16'h0002, 16'h7FFF, 16'h0000, 16'h8000};
`endif
        step(1'b1, {16'hFFFE, 16'h7FFF, 16'h0000, 16'h8000}, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.abs_ans !== want || bus.sign !== 4'b1001 || bus.ovf !== 4'b0001) begin
            errors++; $display("FAIL multilane got v%b %h %b %b want v1 %h 1001 0001", bus.out_valid, bus.abs_ans, bus.sign, bus.ovf, want);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        lat_chk = 1;
        for (int i = 0; i < 20; i++) step(1'b1, rand_data(), 1'b1, 1'b0);
        drain();
        lat_chk = 0;
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] d;
        int            base;
        int            sent;
        base = n_pushed;
        n_rdy_low = 0;
        sent = 0;
        for (int t = 0; t < 100 && sent < 8; t++) begin
            d = rand_data();
            d[NW-1:0] = NW'(-(sent + 1));
            step(1'b1, d, !(t >= 3 && t < 8), 1'b0);
            sent = n_pushed - base;
        end
        checks++;
        if (sent != 8) begin errors++; $display("FAIL bp_sent got %0d want 8", sent); end
        checks++;
        if (n_rdy_low == 0) begin errors++; $display("FAIL bp_in_ready_low got 0 low cycles want >0"); end
        drain();
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) step($urandom_range(0, 3) != 0, rand_data(), $urandom_range(0, 3) != 0, 1'b0);
        drain();
    endtask

    task automatic test_reset_midstream();
        step(1'b1, DW'(16'h8000), 1'b0, 1'b0);
        step(1'b1, rand_data(), 1'b0, 1'b0);
        step(1'b1, rand_data(), 1'b1, 1'b1);
        checks++;
        if (bus.out_valid !== 1'b0 || ovf_count !== '0) begin
            errors++; $display("FAIL reset_mid got v%b cnt %0d want v0 cnt 0", bus.out_valid, ovf_count);
        end
        for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_saturation();
        step(1'b0, '0, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b1, DW'(16'h8000), 1'b1, 1'b0);
        drain();
        checks++;
        if (ovf_count !== 3'd7) begin errors++; $display("FAIL saturation got %0d want 7", ovf_count); end
    endtask

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.ans = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_directed();
        test_overflow();
        test_multilane();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_reset_midstream();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
